// File: rtl/pipe_pkg.sv
// Shared types and defaults for the inter-stage pipeline register.
package pipe_pkg;
    localparam int unsigned PIPE_CNT_W_DEF = 16;
    localparam int unsigned PIPE_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b10
    } pipe_state_t;
endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-wide enable flop with asynchronous reset to RESET_VAL.
module pipe_data_reg #(
    parameter int unsigned          WIDTH     = 32,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       q_o <= RESET_VAL;
        else if (en_i) q_o <= d_i;
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with 2-entry skid buffer, registered in_ready and flush.
// Optional stall counter enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = PIPE_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      CNT_W     = PIPE_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);
    pipe_state_t      state_q;
    logic             in_ready_q;
    logic             in_fire, out_fire;
    logic             main_en, skid_en;
    logic [WIDTH-1:0] main_d, main_q, skid_q;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    // Flush suppresses every data load; held payloads are left in place.
    assign main_en = !flush_i & (((state_q == EMPTY) & in_fire)
                               | ((state_q == FULL) & out_fire & in_fire)
                               | ((state_q == SKID) & out_fire));
    assign skid_en = !flush_i & (state_q == FULL) & !out_fire & in_fire;
    assign main_d  = (state_q == SKID) ? skid_q : in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else if (flush_i) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) state_q <= FULL;
                FULL: begin
                    if (out_fire && !in_fire) begin
                        state_q <= EMPTY;
                    end else if (!out_fire && in_fire) begin
                        state_q    <= SKID;
                        in_ready_q <= 1'b0;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        state_q    <= FULL;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    pipe_data_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk (clk),
        .rst (rst),
        .en_i(main_en),
        .d_i (main_d),
        .q_o (main_q)
    );

    pipe_data_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk (clk),
        .rst (rst),
        .en_i(skid_en),
        .d_i (in_data),
        .q_o (skid_q)
    );

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (out_valid && !out_ready && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif
endmodule
